phase_tracker: RTL
==================

# phase_tracker

Receive-side checker and decoder for the one-hot sub-cycle phase strobes that sequence the single-cycle datapath (IF, ID, EX, MEM, WB).
- Converts the one-hot strobe vector back into an encoded phase index.
- Verifies that phases arrive strictly in order and never overlap.
- Counts completed instructions (full IF..WB sequences).
- Sits beside the datapath as a debug/monitor endpoint, feeding the status/trace logic.

## Interface
- N, 5, number of phases per instruction; strobe bit k = phase k (0 = IF … N-1 = WB)
- IDX_W, 3, width of encoded phase index; must satisfy 2^IDX_W ≥ N
- CNT_W, 32, width of retired-instruction counter
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous assert, active-low
- phase_strb  input  N  phase strobes sampled at rising clk; all-zero = idle cycle
- clr_err  input  1  synchronous clear of sticky error state
- phase_idx  output  IDX_W  encoded index of last accepted phase
- phase_vld  output  1  one-cycle pulse: phase_idx updated this cycle
- retire  output  1  one-cycle pulse: an in-order phase N-1 was accepted
- retire_cnt  output  CNT_W  count of retire pulses
- locked  output  1  tracker synchronised to the phase sequence
- err_onehot  output  1  sticky: multi-hot strobe seen
- err_order  output  1  sticky: out-of-order phase seen
- err_phase  output  IDX_W  expected phase index at first error since last clear

## Operation
- Decode
  - popcount(phase_strb)==0: idle; no state change.
  - popcount==1: valid strobe; idx = bit position.
  - popcount>1: multi-hot error.
- FSM states: HUNT, LOCKED; internal expect register, IDX_W bits.
- HUNT
  - Valid idx==0 → LOCKED, expect=1, phase_vld pulse, phase_idx=0.
  - Any other valid idx is ignored: no error, no phase_vld.
  - Multi-hot → err_onehot set, stay in HUNT.
- LOCKED
  - Valid idx==expect → phase_vld pulse, phase_idx=idx.
    - If expect==N-1: retire pulse, retire_cnt+1, expect=0.
    - Otherwise: expect+1.
  - Valid idx≠expect → err_order set.
    - If idx==0: resynchronise immediately; stay LOCKED, expect=1, phase_vld pulse, no retire.
    - Otherwise: go to HUNT, no phase_vld.
  - Multi-hot → err_onehot set, go to HUNT, no phase_vld.
  - Idle cycles are allowed between any phases; expect is held.
- err_phase
  - Captured only when both sticky flags are 0 (first error since clear).
  - Value = expect in LOCKED, 0 in HUNT.
- clr_err
  - Clears err_onehot, err_order and err_phase.
  - An error detected in the same cycle wins: flag set, err_phase captured fresh.
- retire_cnt wraps modulo 2^CNT_W with no saturation; clr_err does not clear it.
- locked = (state==LOCKED).

## Timing
- All outputs are registered; one-cycle latency from the sampling edge to the output.
- phase_vld and retire are single-cycle pulses and may assert on consecutive cycles.
- retire and the retire_cnt increment are visible in the same cycle.
- Reset (rst low, asynchronous, any time including mid-sequence) forces:
  - state=HUNT, expect=0
  - phase_idx=0, phase_vld=0, retire=0, retire_cnt=0, locked=0
  - err_onehot=0, err_order=0, err_phase=0
- First edge after rst deasserts: normal sampling.
- Back-to-back full sequences with no idle cycles retire one instruction every N cycles.

## Structure
- Shared package holds:
  - phase index constants: PH_IF=0, PH_ID=1, PH_EX=2, PH_MEM=3, PH_WB=4
  - the FSM state typedef/encodings (HUNT, LOCKED)
  - default N/IDX_W
  - the counter block also uses this package so encodings match.
- One natural sub-module: onehot_decode (combinational).
  - Parameterised by N/IDX_W.
  - Outputs idx, zero flag and multi flag.
- The FSM, counter and error capture stay in the top module.

## Test plan
- Reset, then strobes 00001,00010,00100,01000,10000 on consecutive cycles:
  - phase_idx 0..4 with phase_vld each cycle
  - retire in cycle 5, retire_cnt=1, locked=1, no errors.
- Same sequence with 2 idle cycles inserted after each strobe: identical results; expect held across idles.
- Locked after 00001,00010, then 01000:
  - err_order=1, err_phase=2, locked=0
  - next 00100 ignored
  - 00001 relocks.
- Locked, expect=3, strobe 00101:
  - err_onehot=1, err_phase=3, state HUNT
  - clr_err together with a new 00011 in HUNT leaves err_onehot=1 and err_phase=0.
- retire_cnt preloaded by running 2^CNT_W−1 sequences (CNT_W=4 build: 15 sequences), then 1 more: retire_cnt wraps to 0, retire pulses.
- rst pulsed low between EX and MEM strobes:
  - all outputs 0 during reset
  - subsequent 01000 ignored in HUNT, no error.

Source files
------------

// File: rtl/phase_tracker_pkg.sv
// Shared encodings for the phase tracker: phase indices, FSM states and default sizes.
package phase_tracker_pkg;

  localparam int PH_IF  = 0;
  localparam int PH_ID  = 1;
  localparam int PH_EX  = 2;
  localparam int PH_MEM = 3;
  localparam int PH_WB  = 4;

  localparam int N_DEF     = 5;
  localparam int IDX_W_DEF = 3;
  localparam int CNT_W_DEF = 32;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/phase_tracker_if.sv
// Strobe inputs and monitor outputs of the phase tracker, grouped for the datapath side (master)
// and the tracker (slave). fsm_state exposes the tracker FSM for observation.
interface phase_tracker_if
  import phase_tracker_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic [N-1:0]     phase_strb;
  logic             clr_err;
  logic [IDX_W-1:0] phase_idx;
  logic             phase_vld;
  logic             retire;
  logic [CNT_W-1:0] retire_cnt;
  logic             locked;
  logic             err_onehot;
  logic             err_order;
  logic [IDX_W-1:0] err_phase;
  state_t           fsm_state;

  modport master (
    output phase_strb, clr_err,
    input  phase_idx, phase_vld, retire, retire_cnt, locked,
           err_onehot, err_order, err_phase, fsm_state
  );

  modport slave (
    input  phase_strb, clr_err,
    output phase_idx, phase_vld, retire, retire_cnt, locked,
           err_onehot, err_order, err_phase, fsm_state
  );
endinterface

// File: rtl/phase_tracker_onehot_decode.sv
// Combinational one-hot decoder: bit position of the set strobe plus idle and multi-hot flags.
module phase_tracker_onehot_decode #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     strb,
  output logic [IDX_W-1:0] idx,
  output logic             zero,
  output logic             multi
);
  logic seen;

  // idx is only meaningful when exactly one bit is set; otherwise it tracks the highest set bit.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (strb[k]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        idx  = IDX_W'(k);
      end
    end
    zero = ~seen;
  end
endmodule

// File: rtl/phase_tracker.sv
// Phase-strobe monitor: decodes one-hot strobes, checks ordering, counts retired instructions
// and keeps sticky error flags with the expected phase at the first error.
module phase_tracker
  import phase_tracker_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  phase_tracker_if.slave bus
);
  logic [IDX_W-1:0] dec_idx;
  logic             dec_zero;
  logic             dec_multi;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] expect_q, expect_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             retire_q, retire_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eoh_q, eoh_d;
  logic             eor_q, eor_d;
  logic [IDX_W-1:0] eph_q, eph_d;
  logic             first_err;
  logic [IDX_W-1:0] err_val;

  phase_tracker_onehot_decode #(.N(N), .IDX_W(IDX_W)) u_dec (
    .strb  (bus.phase_strb),
    .idx   (dec_idx),
    .zero  (dec_zero),
    .multi (dec_multi)
  );

  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    idx_d    = idx_q;
    vld_d    = 1'b0;
    retire_d = 1'b0;
    cnt_d    = cnt_q;
    eoh_d    = bus.clr_err ? 1'b0 : eoh_q;
    eor_d    = bus.clr_err ? 1'b0 : eor_q;
    eph_d    = bus.clr_err ? '0 : eph_q;
    // A clear in the same cycle makes a fresh error the first one again.
    first_err = bus.clr_err || !(eoh_q || eor_q);
    err_val   = (state_q == LOCKED) ? expect_q : '0;

    if (!dec_zero) begin
      if (dec_multi) begin
        eoh_d   = 1'b1;
        state_d = HUNT;
        if (first_err) eph_d = err_val;
      end else if (state_q == HUNT) begin
        if (dec_idx == IDX_W'(PH_IF)) begin
          state_d  = LOCKED;
          expect_d = IDX_W'(1);
          idx_d    = dec_idx;
          vld_d    = 1'b1;
        end
      end else if (dec_idx == expect_q) begin
        idx_d = dec_idx;
        vld_d = 1'b1;
        if (expect_q == IDX_W'(N - 1)) begin
          retire_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          expect_d = '0;
        end else begin
          expect_d = expect_q + IDX_W'(1);
        end
      end else begin
        eor_d = 1'b1;
        if (first_err) eph_d = err_val;
        // An unexpected IF is taken as the start of a new instruction.
        if (dec_idx == IDX_W'(PH_IF)) begin
          expect_d = IDX_W'(1);
          idx_d    = dec_idx;
          vld_d    = 1'b1;
        end else begin
          state_d = HUNT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HUNT;
      expect_q <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
      retire_q <= 1'b0;
      cnt_q    <= '0;
      eoh_q    <= 1'b0;
      eor_q    <= 1'b0;
      eph_q    <= '0;
    end else begin
      state_q  <= state_d;
      expect_q <= expect_d;
      idx_q    <= idx_d;
      vld_q    <= vld_d;
      retire_q <= retire_d;
      cnt_q    <= cnt_d;
      eoh_q    <= eoh_d;
      eor_q    <= eor_d;
      eph_q    <= eph_d;
    end
  end

  assign bus.phase_idx  = idx_q;
  assign bus.phase_vld  = vld_q;
  assign bus.retire     = retire_q;
  assign bus.retire_cnt = cnt_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.err_onehot = eoh_q;
  assign bus.err_order  = eor_q;
  assign bus.err_phase  = eph_q;
  assign bus.fsm_state  = state_q;
endmodule
